// File: rtl/core_sequencer_pkg.sv
// Shared constants for the integer core sequencer and decoder:
// state encoding, trap cause codes and supported opcodes.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_EXECUTE    = 3'd4,
    ST_WRITEBACK  = 3'd5,
    ST_TRAP       = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE          = 2'd0,
    TRAP_ILLEGAL       = 2'd1,
    TRAP_FETCH_TIMEOUT = 2'd2
  } trap_cause_e;

  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OP  = 7'b0110011;

  function automatic logic is_supported_opcode(input logic [6:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch over a valid/ready imem port, hold the
// instruction for the decoder, sequence execute/writeback, trap on faults.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] insn,
  input  logic        dec_rd_enable_write,
  input  logic [4:0]  dec_rd,
  output logic        rf_write_enable,
  output logic        alu_enable,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int              CNT_W     = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FETCH_TIMEOUT);

  state_e            r_state, w_state_nxt;
  trap_cause_e       r_cause, w_cause_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic [31:0]       r_insn, w_insn_nxt;
  logic [31:0]       r_instret, w_instret_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause   <= TRAP_NONE;
      r_pc      <= RESET_PC;
      r_insn    <= 32'h0;
      r_instret <= 32'h0;
      r_cnt     <= '0;
    end else begin
      r_cause   <= w_cause_nxt;
      r_pc      <= w_pc_nxt;
      r_insn    <= w_insn_nxt;
      r_instret <= w_instret_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cause_nxt   = r_cause;
    w_pc_nxt      = r_pc;
    w_insn_nxt    = r_insn;
    w_instret_nxt = r_instret;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = ST_FETCH_REQ;
        end
      end
      ST_FETCH_REQ: begin
        if (imem_req_ready) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        // A response on the limit cycle takes priority over the timeout.
        if (imem_rsp_valid) begin
          w_insn_nxt  = imem_rsp_data;
          w_state_nxt = ST_DECODE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_LIMIT) begin
            w_cause_nxt = TRAP_FETCH_TIMEOUT;
            w_state_nxt = ST_TRAP;
          end
        end
      end
      ST_DECODE: begin
        if (is_supported_opcode(r_insn[6:0])) begin
          w_state_nxt = ST_EXECUTE;
        end else begin
          w_cause_nxt = TRAP_ILLEGAL;
          w_state_nxt = ST_TRAP;
        end
      end
      ST_EXECUTE: begin
        w_state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_pc_nxt      = r_pc + 32'd4;
        w_instret_nxt = r_instret + 32'd1;
        w_state_nxt   = ST_FETCH_REQ;
      end
      ST_TRAP: begin
        if (start) begin
          w_cause_nxt = TRAP_NONE;
          w_pc_nxt    = RESET_PC;
          w_state_nxt = ST_FETCH_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign imem_req_valid  = (r_state == ST_FETCH_REQ);
  assign imem_req_addr   = r_pc;
  assign insn            = r_insn;
  assign alu_enable      = (r_state == ST_EXECUTE);
  assign rf_write_enable = (r_state == ST_WRITEBACK) && dec_rd_enable_write && (dec_rd != 5'd0);
  assign pc              = r_pc;
  assign instret         = r_instret;
  assign busy            = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign trap            = (r_state == ST_TRAP);
  assign trap_cause      = r_cause;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer with a transaction-level
// model tracking pc, retired count and expected trap outcomes.
module tb_core_sequencer;

  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  localparam int          TMO = 12;
  localparam logic [6:0]  LUI = 7'b0110111;
  localparam logic [6:0]  OPR = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] insn;
  logic        dec_rd_enable_write = 1'b0;
  logic [4:0]  dec_rd = 5'd0;
  logic        rf_write_enable;
  logic        alu_enable;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        busy;
  logic        trap;
  logic [1:0]  trap_cause;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_instret = 32'h0;
  logic        m_trap = 1'b0;

  core_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .insn(insn),
    .dec_rd_enable_write(dec_rd_enable_write), .dec_rd(dec_rd),
    .rf_write_enable(rf_write_enable), .alu_enable(alu_enable),
    .pc(pc), .instret(instret), .busy(busy), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leave IDLE or TRAP with a one-cycle start pulse; afterwards the DUT is in FETCH_REQ.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kick_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    m_pc = RPC;
    m_trap = 1'b0;
  endtask

  // One instruction from FETCH_REQ; rsp_dly >= TMO means the memory never answers.
  task automatic do_insn(input logic [31:0] data, input int rdy_dly, input int rsp_dly,
                         input logic we, input logic [4:0] rd);
    logic legal;
    logic got;
    legal = (data[6:0] == LUI) || (data[6:0] == OPR);
    got = 1'b0;
    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      imem_req_ready = (k == rdy_dly);
      imem_rsp_valid = (k != rdy_dly) && ($urandom_range(1, 0) == 1);
      imem_rsp_data  = 32'hDEAD_0013;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc || alu_enable !== 1'b0 || rf_write_enable !== 1'b0) begin
        n_fail++; $display("FAIL req_hold: valid=%b addr=%h alu=%b rfwe=%b, want 1 %h 0 0", imem_req_valid, imem_req_addr, alu_enable, rf_write_enable, m_pc);
      end
      if (k == 0) begin
        n_cmp++; if (pc !== m_pc || instret !== m_instret || trap_cause !== 2'd0 || busy !== 1'b1 || trap !== 1'b0) begin
          n_fail++; $display("FAIL arch_state: pc=%h instret=%0d cause=%0d busy=%b trap=%b, want %h %0d 0 1 0", pc, instret, trap_cause, busy, trap, m_pc, m_instret);
        end
      end
    end
    for (int j = 0; j < TMO; j++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = (j == rsp_dly);
      imem_rsp_data  = data;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0 || busy !== 1'b1 || trap !== 1'b0) begin
        n_fail++; $display("FAIL wait_state: valid=%b busy=%b trap=%b at wait cycle %0d, want 0 1 0", imem_req_valid, busy, trap, j);
      end
      if (j == rsp_dly) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      #1;
      n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd2 || busy !== 1'b0 || pc !== m_pc) begin
        n_fail++; $display("FAIL timeout_trap: trap=%b cause=%0d busy=%b pc=%h, want 1 2 0 %h", trap, trap_cause, busy, pc, m_pc);
      end
      m_trap = 1'b1;
      return;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    #1;
    n_cmp++; if (insn !== data || alu_enable !== 1'b0 || rf_write_enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL decode: insn=%h alu=%b rfwe=%b busy=%b, want %h 0 0 1", insn, alu_enable, rf_write_enable, busy, data);
    end
    if (!legal) begin
      @(negedge clk);
      #1;
      n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd1 || busy !== 1'b0 || pc !== m_pc || alu_enable !== 1'b0) begin
        n_fail++; $display("FAIL illegal_trap: trap=%b cause=%0d busy=%b pc=%h alu=%b, want 1 1 0 %h 0", trap, trap_cause, busy, pc, alu_enable, m_pc);
      end
      m_trap = 1'b1;
      return;
    end
    @(negedge clk);
    #1;
    n_cmp++; if (alu_enable !== 1'b1 || rf_write_enable !== 1'b0 || insn !== data) begin
      n_fail++; $display("FAIL execute: alu=%b rfwe=%b insn=%h, want 1 0 %h", alu_enable, rf_write_enable, insn, data);
    end
    @(negedge clk);
    dec_rd_enable_write = we;
    dec_rd = rd;
    #1;
    n_cmp++; if (rf_write_enable !== (we && rd != 5'd0) || alu_enable !== 1'b0 || insn !== data) begin
      n_fail++; $display("FAIL writeback: rfwe=%b alu=%b insn=%h, want %b 0 %h", rf_write_enable, alu_enable, insn, (we && rd != 5'd0), data);
    end
    m_pc = m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || pc !== RPC || insn !== 32'h0 || instret !== 32'h0 || trap_cause !== 2'd0 ||
                 alu_enable !== 1'b0 || rf_write_enable !== 1'b0 || busy !== 1'b0 || trap !== 1'b0) begin
      n_fail++; $display("FAIL reset_values: valid=%b pc=%h insn=%h instret=%0d cause=%0d alu=%b rfwe=%b busy=%b trap=%b", imem_req_valid, pc, insn, instret, trap_cause, alu_enable, rf_write_enable, busy, trap);
    end
  endtask

  // start stays high through reset release and the whole first instruction.
  task automatic test_first_insn();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_pc = RPC;
    m_instret = 32'h0;
    do_insn(32'h002081B3, 0, 0, 1'b1, 5'd3);
    start = 1'b0;
  endtask

  task automatic test_lui_then_nop();
    do_insn(32'h123452B7, 0, 0, 1'b1, 5'd5);
    do_insn(32'h00000033, 0, 0, 1'b1, 5'd0);
    @(negedge clk);
    #1;
    n_cmp++; if (pc !== 32'h0000_0004 || instret !== 32'd3) begin
      n_fail++; $display("FAIL pc_wrap: pc=%h instret=%0d, want 00000004 3", pc, instret);
    end
  endtask

  task automatic test_ready_stall();
    do_insn(32'h002081B3, 3, 1, 1'b1, 5'd3);
  endtask

  task automatic test_illegal();
    do_insn(32'h00000013, 0, 0, 1'b1, 5'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
      n_cmp++; if (trap !== 1'b1 || trap_cause !== 2'd1 || pc !== m_pc || busy !== 1'b0) begin
        n_fail++; $display("FAIL trap_hold: trap=%b cause=%0d pc=%h busy=%b, want 1 1 %h 0", trap, trap_cause, pc, busy, m_pc);
      end
    end
    kick();
    do_insn(32'h00A00033, 0, 0, 1'b0, 5'd0);
  endtask

  task automatic test_timeout();
    do_insn(32'h002081B3, 1, TMO, 1'b1, 5'd3);
    kick();
    do_insn(32'h002081B3, 0, TMO - 1, 1'b1, 5'd3);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || pc !== RPC || insn !== 32'h0 || instret !== 32'h0 || trap_cause !== 2'd0 || busy !== 1'b0 || trap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: valid=%b pc=%h insn=%h instret=%0d cause=%0d busy=%b trap=%b", imem_req_valid, pc, insn, instret, trap_cause, busy, trap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h002081B3;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    repeat (3) begin
      #1;
      n_cmp++; if (busy !== 1'b0 || insn !== 32'h0 || imem_req_valid !== 1'b0 || trap !== 1'b0) begin
        n_fail++; $display("FAIL late_rsp: busy=%b insn=%h valid=%b trap=%b, want 0 0 0 0", busy, insn, imem_req_valid, trap);
      end
      @(negedge clk);
    end
    m_pc = RPC;
    m_instret = 32'h0;
    m_trap = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] data;
    logic [6:0]  opc;
    int          rsp;
    for (int i = 0; i < 40; i++) begin
      if (m_trap) kick();
      data = $urandom;
      case ($urandom_range(3, 0))
        0:       opc = LUI;
        1, 2:    opc = OPR;
        default: begin
          opc = 7'($urandom);
          if (opc == LUI || opc == OPR) opc = 7'h13;
        end
      endcase
      data[6:0] = opc;
      rsp = ($urandom_range(7, 0) == 0) ? TMO : $urandom_range(TMO - 1, 0);
      do_insn(data, $urandom_range(3, 0), rsp, 1'($urandom), 5'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_first_insn();
    test_lui_then_nop();
    test_ready_stall();
    test_illegal();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
